// File: rtl/pong_game_ctrl_if.sv
// ============================================================================
//  Module   : pong_game_ctrl_if
//  Purpose  : Paddle/tick inputs and ball/score outputs of the Pong sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       btn_start;
    logic [9:0] left_bar_y;
    logic [9:0] right_bar_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [2:0] game_state;
    logic       game_over;

    modport master (
        output frame_tick, btn_start, left_bar_y, right_bar_y,
        input  ball_x, ball_y, score_left, score_right, game_state, game_over
    );

    modport slave (
        input  frame_tick, btn_start, left_bar_y, right_bar_y,
        output ball_x, ball_y, score_left, score_right, game_state, game_over
    );
endinterface

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
// ============================================================================
//  Module   : pong_game_ctrl
//  Purpose  : Pong game sequencer - ball motion, serve timing, scoring, win.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pong_game_ctrl #(
    parameter int HRES         = 640,
    parameter int VRES         = 480,
    parameter int BAR_WIDTH    = 15,
    parameter int BAR_HEIGHT   = 200,
    parameter int SQUARE_SIZE  = 16,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic            clk,
    input  logic            reset_n,
    pong_game_ctrl_if.slave game
);

    localparam int                 c_CNT_W      = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_SERVE_LAST = c_CNT_W'(SERVE_FRAMES - 1);
    localparam logic [9:0]         c_CX         = 10'((HRES - SQUARE_SIZE) / 2);
    localparam logic [9:0]         c_CY         = 10'((VRES - SQUARE_SIZE) / 2);
    localparam logic [9:0]         c_STEP       = 10'(BALL_SPEED);
    localparam logic [9:0]         c_BAR_W10    = 10'(BAR_WIDTH);
    localparam logic [9:0]         c_YMAX10     = 10'(VRES - SQUARE_SIZE);
    localparam logic [9:0]         c_XLIM10     = 10'(HRES - BAR_WIDTH - SQUARE_SIZE);
    localparam logic [10:0]        c_SPEED11    = 11'(BALL_SPEED);
    localparam logic [10:0]        c_BAR_W11    = 11'(BAR_WIDTH);
    localparam logic [10:0]        c_BAR_H11    = 11'(BAR_HEIGHT);
    localparam logic [10:0]        c_SQ11       = 11'(SQUARE_SIZE);
    localparam logic [10:0]        c_YMAX11     = 11'(VRES - SQUARE_SIZE);
    localparam logic [10:0]        c_XLIM11     = 11'(HRES - BAR_WIDTH - SQUARE_SIZE);
    localparam logic [3:0]         c_WIN        = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [9:0]         r_ball_x, w_ball_x_nxt;
    logic [9:0]         r_ball_y, w_ball_y_nxt;
    logic               r_dx_right, w_dx_right_nxt;
    logic               r_dy_down, w_dy_down_nxt;
    logic [3:0]         r_score_l, w_score_l_nxt;
    logic [3:0]         r_score_r, w_score_r_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_scorer_right, w_scorer_right_nxt;
    logic               r_btn_q;
    logic               r_game_over;

    logic               w_start_edge;
    logic [10:0]        w_bx, w_by, w_ly, w_ry;
    logic               w_left_ovl, w_right_ovl;
    logic [9:0]         w_py_nxt;
    logic               w_pdy_nxt;
    logic [3:0]         w_pt_base, w_pt_score;

    assign w_start_edge = game.btn_start & ~r_btn_q;
    assign w_bx         = {1'b0, r_ball_x};
    assign w_by         = {1'b0, r_ball_y};
    assign w_ly         = {1'b0, game.left_bar_y};
    assign w_ry         = {1'b0, game.right_bar_y};
    assign w_left_ovl   = (w_by + c_SQ11 > w_ly) && (w_by < w_ly + c_BAR_H11);
    assign w_right_ovl  = (w_by + c_SQ11 > w_ry) && (w_by < w_ry + c_BAR_H11);
    assign w_pt_base    = r_scorer_right ? r_score_r : r_score_l;
    assign w_pt_score   = (w_pt_base >= c_WIN) ? c_WIN : w_pt_base + 4'd1;

    // Vertical step with top/bottom wall reflection.
    always_comb begin
        w_py_nxt  = r_ball_y;
        w_pdy_nxt = r_dy_down;
        if (r_dy_down) begin
            if (w_by + c_SPEED11 >= c_YMAX11) begin
                w_py_nxt  = c_YMAX10;
                w_pdy_nxt = 1'b0;
            end else begin
                w_py_nxt  = r_ball_y + c_STEP;
            end
        end else begin
            if (w_by <= c_SPEED11) begin
                w_py_nxt  = '0;
                w_pdy_nxt = 1'b1;
            end else begin
                w_py_nxt  = r_ball_y - c_STEP;
            end
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_ball_x_nxt       = r_ball_x;
        w_ball_y_nxt       = r_ball_y;
        w_dx_right_nxt     = r_dx_right;
        w_dy_down_nxt      = r_dy_down;
        w_score_l_nxt      = r_score_l;
        w_score_r_nxt      = r_score_r;
        w_cnt_nxt          = r_cnt;
        w_scorer_right_nxt = r_scorer_right;
        case (r_state)
            ST_IDLE: begin
                w_ball_x_nxt = c_CX;
                w_ball_y_nxt = c_CY;
                if (w_start_edge) begin
                    w_state_nxt    = ST_SERVE;
                    w_score_l_nxt  = '0;
                    w_score_r_nxt  = '0;
                    w_dx_right_nxt = 1'b1;
                end
            end
            ST_SERVE: begin
                w_ball_x_nxt = c_CX;
                w_ball_y_nxt = c_CY;
                if (game.frame_tick) begin
                    if (r_cnt == c_SERVE_LAST) begin
                        w_state_nxt   = ST_PLAY;
                        w_cnt_nxt     = '0;
                        w_dy_down_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (game.frame_tick) begin
                    w_ball_y_nxt  = w_py_nxt;
                    w_dy_down_nxt = w_pdy_nxt;
                    // Paddle zone is tested before stepping so x never wraps below zero.
                    if (!r_dx_right) begin
                        if (w_bx <= c_BAR_W11 + c_SPEED11) begin
                            if (w_left_ovl) begin
                                w_ball_x_nxt   = c_BAR_W10;
                                w_dx_right_nxt = 1'b1;
                            end else begin
                                w_state_nxt        = ST_POINT;
                                w_scorer_right_nxt = 1'b1;
                                w_ball_y_nxt       = r_ball_y;
                                w_dy_down_nxt      = r_dy_down;
                            end
                        end else begin
                            w_ball_x_nxt = r_ball_x - c_STEP;
                        end
                    end else begin
                        if (w_bx + c_SPEED11 >= c_XLIM11) begin
                            if (w_right_ovl) begin
                                w_ball_x_nxt   = c_XLIM10;
                                w_dx_right_nxt = 1'b0;
                            end else begin
                                w_state_nxt        = ST_POINT;
                                w_scorer_right_nxt = 1'b0;
                                w_ball_y_nxt       = r_ball_y;
                                w_dy_down_nxt      = r_dy_down;
                            end
                        end else begin
                            w_ball_x_nxt = r_ball_x + c_STEP;
                        end
                    end
                end
            end
            ST_POINT: begin
                if (r_scorer_right) w_score_r_nxt = w_pt_score;
                else                w_score_l_nxt = w_pt_score;
                if (w_pt_score == c_WIN) begin
                    w_state_nxt = ST_OVER;
                end else begin
                    w_state_nxt    = ST_SERVE;
                    w_ball_x_nxt   = c_CX;
                    w_ball_y_nxt   = c_CY;
                    w_dx_right_nxt = ~r_scorer_right;
                    w_cnt_nxt      = '0;
                end
            end
            ST_OVER: begin
                if (w_start_edge) begin
                    w_state_nxt   = ST_IDLE;
                    w_ball_x_nxt  = c_CX;
                    w_ball_y_nxt  = c_CY;
                    w_score_l_nxt = '0;
                    w_score_r_nxt = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_ball_x       <= c_CX;
            r_ball_y       <= c_CY;
            r_dx_right     <= 1'b1;
            r_dy_down      <= 1'b1;
            r_score_l      <= '0;
            r_score_r      <= '0;
            r_cnt          <= '0;
            r_scorer_right <= 1'b0;
            r_btn_q        <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ball_x       <= w_ball_x_nxt;
            r_ball_y       <= w_ball_y_nxt;
            r_dx_right     <= w_dx_right_nxt;
            r_dy_down      <= w_dy_down_nxt;
            r_score_l      <= w_score_l_nxt;
            r_score_r      <= w_score_r_nxt;
            r_cnt          <= w_cnt_nxt;
            r_scorer_right <= w_scorer_right_nxt;
            r_btn_q        <= game.btn_start;
            r_game_over    <= (w_state_nxt == ST_OVER);
        end
    end

    assign game.ball_x      = r_ball_x;
    assign game.ball_y      = r_ball_y;
    assign game.score_left  = r_score_l;
    assign game.score_right = r_score_r;
    assign game.game_state  = r_state;
    assign game.game_over   = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// ============================================================================
//  Module   : tb_pong_game_ctrl
//  Purpose  : Randomised and directed checks of pong_game_ctrl against a game model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pong_game_ctrl;
    localparam int HRES = 640, VRES = 480, BW = 15, BH = 200, SQ = 16, SPD = 2, SF = 4, WIN = 2;
    localparam int YMAX = VRES - SQ;
    localparam int XLIM = HRES - BW - SQ;
    localparam int CX   = (HRES - SQ) / 2;
    localparam int CY   = (VRES - SQ) / 2;
    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    pong_game_ctrl_if gif ();

    pong_game_ctrl #(
        .HRES(HRES), .VRES(VRES), .BAR_WIDTH(BW), .BAR_HEIGHT(BH), .SQUARE_SIZE(SQ),
        .BALL_SPEED(SPD), .SERVE_FRAMES(SF), .WIN_SCORE(WIN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .game    (gif)
    );

    always #5 clk = ~clk;

    logic [31:0] act;
    assign act = {gif.ball_x, gif.ball_y, gif.score_left, gif.score_right, gif.game_state, gif.game_over};

    // Game model: signed velocities, integer positions, numeric state codes.
    int m_state, m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_cnt;
    bit m_btn_q, m_scorer_right;

    function automatic void model_reset();
        m_state = S_IDLE; m_x = CX; m_y = CY; m_vx = SPD; m_vy = SPD;
        m_sl = 0; m_sr = 0; m_cnt = 0; m_btn_q = 1'b0; m_scorer_right = 1'b0;
    endfunction

    function automatic void model_step(bit tick, bit btn, int lby, int rby);
        bit start;
        bit miss;
        int nx, ny, nvx, nvy, pts;
        start   = btn && !m_btn_q;
        m_btn_q = btn;
        case (m_state)
            S_IDLE: if (start) begin m_state = S_SERVE; m_sl = 0; m_sr = 0; m_vx = SPD; end
            S_SERVE: if (tick) begin
                if (m_cnt == SF - 1) begin m_state = S_PLAY; m_cnt = 0; m_vy = SPD; end
                else m_cnt++;
            end
            S_PLAY: if (tick) begin
                ny = m_y + m_vy; nvy = m_vy;
                if (m_vy > 0 && ny >= YMAX) begin ny = YMAX; nvy = -SPD; end
                else if (m_vy < 0 && ny <= 0) begin ny = 0; nvy = SPD; end
                nx = m_x + m_vx; nvx = m_vx; miss = 1'b0;
                if (m_vx < 0 && nx <= BW) begin
                    if (m_y + SQ > lby && m_y < lby + BH) begin nx = BW; nvx = SPD; end
                    else begin miss = 1'b1; m_scorer_right = 1'b1; end
                end else if (m_vx > 0 && nx >= XLIM) begin
                    if (m_y + SQ > rby && m_y < rby + BH) begin nx = XLIM; nvx = -SPD; end
                    else begin miss = 1'b1; m_scorer_right = 1'b0; end
                end
                if (miss) m_state = S_POINT;
                else begin m_x = nx; m_y = ny; m_vx = nvx; m_vy = nvy; end
            end
            S_POINT: begin
                pts = (m_scorer_right ? m_sr : m_sl) + 1;
                if (pts > WIN) pts = WIN;
                if (m_scorer_right) m_sr = pts; else m_sl = pts;
                if (pts == WIN) m_state = S_OVER;
                else begin
                    m_state = S_SERVE; m_x = CX; m_y = CY; m_cnt = 0;
                    m_vx = m_scorer_right ? -SPD : SPD;
                end
            end
            S_OVER: if (start) begin m_state = S_IDLE; m_x = CX; m_y = CY; m_sl = 0; m_sr = 0; end
            default: m_state = S_IDLE;
        endcase
    endfunction

    function automatic logic [31:0] exp_vec();
        return {10'(m_x), 10'(m_y), 4'(m_sl), 4'(m_sr), 3'(m_state), logic'(m_state == S_OVER)};
    endfunction

    // Paddle top that covers (hit=1) or clears (hit=0) the ball's current row.
    function automatic int bar_pos(bit hit);
        int b;
        if (hit) begin
            b = m_y - int'($urandom_range(199, 0));
            if (b < 0) b = 0;
        end else begin
            b = m_y + SQ + int'($urandom_range(300, 0));
        end
        return b;
    endfunction

    task automatic cycle(input bit tick, input bit btn, input int lby, input int rby);
        gif.frame_tick  = tick;
        gif.btn_start   = btn;
        gif.left_bar_y  = 10'(lby);
        gif.right_bar_y = 10'(rby);
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_step(tick, btn, lby, rby);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rst_vec;
        rst_vec = {10'd312, 10'd232, 4'd0, 4'd0, 3'd0, 1'b0};
        reset_n = 1'b0;
        model_reset();
        repeat (2) cycle(1'b0, 1'b0, 0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(i % 2 == 0, 1'b0, 0, 0);
            n_cmp++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_model cyc %0d: got %h want %h", i, act, exp_vec());
            end
            n_cmp++;
            if (act !== rst_vec) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", i, act, rst_vec);
            end
        end
    endtask

    task automatic test_serve();
        int entries;
        logic [2:0] prev;
        entries = 0;
        prev = gif.game_state;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 0, 0);
            if (prev !== 3'd1 && gif.game_state === 3'd1) entries++;
            prev = gif.game_state;
            n_cmp++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL serve_hold cyc %0d: got %h want %h", i, act, exp_vec());
            end
        end
        n_cmp++;
        if (entries !== 1) begin
            n_fail++;
            $display("FAIL serve_entries: got %0d want 1", entries);
        end
        for (int t = 1; t <= SF; t++) begin
            cycle(1'b1, t[0], 0, 0);
            n_cmp++;
            if (gif.game_state !== ((t < SF) ? 3'd1 : 3'd2) || act !== exp_vec()) begin
                n_fail++;
                $display("FAIL serve_tick %0d: got %h want %h", t, act, exp_vec());
            end
            cycle(1'b0, 1'b0, 0, 0);
        end
        cycle(1'b1, 1'b0, 0, 0);
        n_cmp++;
        if (gif.ball_x !== 10'd314 || gif.ball_y !== 10'd234) begin
            n_fail++;
            $display("FAIL first_play_tick: got (%0d,%0d) want (314,234)", gif.ball_x, gif.ball_y);
        end
    endtask

    task automatic test_left_miss();
        int guard;
        guard = 0;
        while (m_state != S_POINT && guard < 3000) begin
            cycle(1'b1, 1'b0, bar_pos(1'b0), bar_pos(1'b1));
            guard++;
            n_cmp++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL left_miss_play cyc %0d: got %h want %h", guard, act, exp_vec());
            end
        end
        cycle(1'b1, 1'b0, 0, 0);
        n_cmp++;
        if (gif.score_right !== 4'd1 || gif.score_left !== 4'd0 || gif.game_state !== 3'd1) begin
            n_fail++;
            $display("FAIL left_miss_score: got R%0d L%0d st%0d want R1 L0 st1",
                     gif.score_right, gif.score_left, gif.game_state);
        end
        repeat (SF) cycle(1'b1, 1'b0, 0, 0);
        cycle(1'b1, 1'b0, 0, 0);
        n_cmp++;
        if (gif.ball_x !== 10'd310 || gif.ball_y !== 10'd234 || act !== exp_vec()) begin
            n_fail++;
            $display("FAIL serve_toward_loser: got (%0d,%0d) want (310,234)", gif.ball_x, gif.ball_y);
        end
    endtask

    task automatic test_game_over();
        int guard;
        guard = 0;
        while (m_state != S_OVER && guard < 5000) begin
            cycle(1'b1, 1'b0, bar_pos(1'b1), bar_pos(1'b0));
            guard++;
            n_cmp++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL over_play cyc %0d: got %h want %h", guard, act, exp_vec());
            end
        end
        n_cmp++;
        if (gif.score_left !== 4'd2 || gif.game_over !== 1'b1 || gif.game_state !== 3'd4) begin
            n_fail++;
            $display("FAIL game_over: got L%0d go%0b st%0d want L2 go1 st4",
                     gif.score_left, gif.game_over, gif.game_state);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 0, 0);
            n_cmp++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL over_frozen cyc %0d: got %h want %h", i, act, exp_vec());
            end
        end
        cycle(1'b0, 1'b1, 0, 0);
        cycle(1'b0, 1'b0, 0, 0);
        n_cmp++;
        if (act !== {10'd312, 10'd232, 4'd0, 4'd0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL over_restart: got %h want %h", act, {10'd312, 10'd232, 4'd0, 4'd0, 3'd0, 1'b0});
        end
    endtask

    task automatic test_random_rally();
        bit tick, btn;
        for (int i = 0; i < 15000; i++) begin
            tick = 1'($urandom_range(1, 0));
            btn  = ($urandom_range(31, 0) == 0);
            cycle(tick, btn, bar_pos($urandom_range(3, 0) != 0), bar_pos($urandom_range(3, 0) != 0));
            n_cmp++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL rally cyc %0d: got %h want %h", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        reset_n = 1'b0;
        cycle(1'b0, 1'b0, 0, 0);
        reset_n = 1'b1;
        cycle(1'b0, 1'b1, 0, 0);
        cycle(1'b0, 1'b0, 0, 0);
        repeat (SF + 20) cycle(1'b1, 1'b0, bar_pos(1'b1), bar_pos(1'b1));
        n_cmp++;
        if (gif.game_state !== 3'd2 || act !== exp_vec()) begin
            n_fail++;
            $display("FAIL areset_setup: got %h want %h", act, exp_vec());
        end
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (act !== {10'd312, 10'd232, 4'd0, 4'd0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL areset_immediate: got %h want %h", act, {10'd312, 10'd232, 4'd0, 4'd0, 3'd0, 1'b0});
        end
        repeat (3) cycle(1'b1, 1'b0, 0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, 0, 0);
            n_cmp++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL areset_idle cyc %0d: got %h want %h", i, act, exp_vec());
            end
        end
    endtask

    initial begin
        gif.frame_tick  = 1'b0;
        gif.btn_start   = 1'b0;
        gif.left_bar_y  = '0;
        gif.right_bar_y = '0;
        model_reset();
        test_reset();
        test_serve();
        test_left_miss();
        test_game_over();
        test_random_rally();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire
